// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and constants for the load/store bus sequencer.
// Imported by the sequencer top and its load alignment helper.
package mem_access_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic MEM_SIZE_BYTE = 1'b0;
  localparam logic MEM_SIZE_WORD = 1'b1;

  localparam int TIMEOUT_DEFAULT = 16;

  function automatic logic [3:0] lane_be(
    input logic       sz,
    input logic [1:0] lane
  );
    return (sz == MEM_SIZE_WORD) ? 4'b1111
                                 : (4'b0001 << lane);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_load_align.sv
// Load data alignment: picks a byte lane and sign-extends it,
// or passes a full word through untouched.
module load_align
  import mem_access_sequencer_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic        i_size,
  output logic [31:0] o_data
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    if (i_size == MEM_SIZE_WORD)
      o_data = i_word;
    else
      o_data = {{24{w_byte[7]}}, w_byte};
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Core load/store sequencer: one outstanding bus access with
// alignment checks, ack timeout and a single-cycle done pulse.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  state_e      w_next;

  logic [31:0] r_addr;
  logic [1:0]  r_lane;
  logic        r_size;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [7:0]  r_wait;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_illegal;
  logic        w_accept;
  logic        w_reject;
  logic        w_ack_ok;
  logic        w_timeout;
  logic [31:0] w_load;

  load_align u_align (
    .i_word (bus_rdata),
    .i_lane (r_lane),
    .i_size (r_size),
    .o_data (w_load)
  );

  always_comb begin
    w_req     = mem_read | mem_write;
    w_illegal = (mem_read & mem_write) |
                ((mem_size == MEM_SIZE_WORD) &
                 (addr[1:0] != 2'b00));
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    w_ack_ok  = 1'b0;
    w_timeout = 1'b0;
    w_next    = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept = ~w_illegal;
          w_reject = w_illegal;
          w_next   = w_illegal ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        // ack wins over a timeout landing on the same cycle
        if (bus_ack) begin
          w_ack_ok = 1'b1;
          w_next   = S_DONE;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_lane  <= '0;
      r_size  <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= {addr[31:2], 2'b00};
        r_lane  <= addr[1:0];
        r_size  <= mem_size;
        r_we    <= mem_write;
        r_be    <= lane_be(mem_size, addr[1:0]);
        r_wdata <= (mem_size == MEM_SIZE_WORD) ? wdata
                                               : {4{wdata[7:0]}};
        r_wait  <= '0;
      end else if ((r_state == S_BUSY) && !bus_ack &&
                   !w_timeout) begin
        r_wait <= r_wait + 8'd1;
      end
      if (w_reject | w_timeout)
        r_err <= 1'b1;
      else if (w_ack_ok)
        r_err <= 1'b0;
      if (w_ack_ok & ~r_we)
        r_rdata <= w_load;
    end
  end

  assign done      = (r_state == S_DONE);
  assign bus_req   = (r_state == S_BUSY);
  assign bus_we    = bus_req & r_we;
  assign bus_be    = bus_req ? r_be : 4'b0000;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign stall     = w_req & ~done;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a cycle-level
// reference model of request/ack/timeout behaviour.
module tb_mem_access_sequencer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, mem_size;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_rdata;
  logic        m_err;

  int          obs_done_c, obs_nreq;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we, obs_err;

  mem_access_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_size  (mem_size),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ack_at: index of the BUSY cycle carrying bus_ack, -1 = never
  task automatic access(input logic rd, input logic wr,
                        input logic sz, input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [31:0] brd, input int ack_at);
    logic        illegal, success;
    int          n_busy, done_c, lane;
    logic [31:0] e_addr, e_wdata, e_load;
    logic [3:0]  e_be;
    logic [7:0]  b;
    illegal = (rd && wr) || (sz && (a[1:0] != 2'b00));
    success = !illegal && ack_at >= 0 && ack_at < T;
    n_busy  = illegal ? 0 : (success ? ack_at + 1 : T);
    done_c  = n_busy + 1;
    lane    = int'(a[1:0]);
    e_addr  = {a[31:2], 2'b00};
    e_be    = sz ? 4'b1111 : (4'b0001 << lane);
    e_wdata = sz ? wd : {4{wd[7:0]}};
    b       = brd[8*lane +: 8];
    e_load  = sz ? brd : {{24{b[7]}}, b};
    obs_done_c = -1;
    obs_nreq   = 0;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mem_read = rd; mem_write = wr; mem_size = sz;
        addr = a; wdata = wd;
      end
      bus_ack   = (ack_at >= 0) && (c == ack_at + 1);
      bus_rdata = brd;
      #1;
      chk1("stall", stall, c != done_c);
      chk1("bus_req", bus_req, c >= 1 && c <= n_busy);
      chk1("done", done, c == done_c);
      if (bus_req) begin
        obs_nreq++;
        obs_addr = bus_addr; obs_be = bus_be;
        obs_wdata = bus_wdata; obs_we = bus_we;
        chk32("bus_addr", bus_addr, e_addr);
        chk32("bus_be", {28'd0, bus_be}, {28'd0, e_be});
        chk1("bus_we", bus_we, wr);
        chk32("bus_wdata", bus_wdata, e_wdata);
      end
      if (done && obs_done_c < 0) obs_done_c = c;
      if (c == done_c) begin
        m_err = !success;
        if (success && rd) m_rdata = e_load;
        obs_err = err;
        chk1("err", err, m_err);
        chk32("rdata", rdata, m_rdata);
        mem_read = 1'b0; mem_write = 1'b0;
      end
    end
    bus_ack = 1'b0;
  endtask

  task automatic idle(input logic stray_ack);
    @(negedge clk);
    bus_ack = stray_ack;
    #1;
    chk1("idle_req", bus_req, 1'b0);
    chk1("idle_done", done, 1'b0);
    chk1("idle_stall", stall, 1'b0);
    chk1("idle_err_hold", err, m_err);
    chk32("idle_rdata_hold", rdata, m_rdata);
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 0; mem_write = 0; mem_size = 0;
    addr = '0; wdata = '0; bus_ack = 0; bus_rdata = '0;
    m_rdata = '0; m_err = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk1("rst_req", bus_req, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk32("rst_rdata", rdata, 32'h0);
    chk32("rst_be", {28'd0, bus_be}, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    access(1, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    chk32("t1_addr", obs_addr, 32'h100);
    chk32("t1_be", {28'd0, obs_be}, 32'hF);
    chk32("t1_done_cycle", obs_done_c, 32'd2);
    chk32("t1_rdata", rdata, 32'hDEADBEEF);
    chk1("t1_err", obs_err, 1'b0);
    idle(0);

    access(1, 0, 0, 32'h103, 32'h0, 32'h80FFFFFF, 1);
    chk32("t2_be", {28'd0, obs_be}, 32'h8);
    chk32("t2_rdata", rdata, 32'hFFFFFF80);
    idle(0);

    access(0, 1, 0, 32'h201, 32'h12345678, 32'h0, 0);
    chk32("t3_addr", obs_addr, 32'h200);
    chk32("t3_be", {28'd0, obs_be}, 32'h2);
    chk32("t3_wdata", obs_wdata, 32'h78787878);
    chk1("t3_we", obs_we, 1'b1);
    idle(0);

    access(1, 0, 1, 32'h102, 32'h0, 32'h0, 0);
    chk32("t4_nreq", obs_nreq, 32'd0);
    chk32("t4_done_cycle", obs_done_c, 32'd1);
    chk1("t4_err", obs_err, 1'b1);
    idle(0);

    access(1, 1, 0, 32'h10, 32'h0, 32'h0, 0);
    idle(0);

    access(1, 0, 1, 32'h400, 32'h0, 32'h11111111, -1);
    chk32("t6_nreq", obs_nreq, 32'd4);
    chk1("t6_err", obs_err, 1'b1);
    idle(0);

    access(1, 0, 1, 32'h404, 32'h0, 32'hCAFEF00D, 3);
    chk32("t7_nreq", obs_nreq, 32'd4);
    chk1("t7_err", obs_err, 1'b0);
    chk32("t7_rdata", rdata, 32'hCAFEF00D);
    idle(0);

    access(1, 0, 1, 32'h408, 32'h0, 32'h22222222, T);
    idle(0);

    access(0, 1, 1, 32'h40C, 32'hA5A5_0F0F, 32'h0, 2);
    idle(0);

    access(1, 0, 0, 32'h500, 32'h0, 32'h33221144, 0);
    access(1, 0, 0, 32'h501, 32'h0, 32'h33221144, 0);
    chk32("t10_rdata", rdata, 32'h00000011);
    access(1, 0, 0, 32'h502, 32'h0, 32'hFF7F0000, 0);
    chk32("t11_rdata", rdata, 32'h0000007F);

    idle(1);
    idle(0);

    @(negedge clk);
    mem_read = 1; mem_write = 0; mem_size = 1;
    addr = 32'h300; bus_ack = 0;
    @(negedge clk); @(negedge clk);
    #1 chk1("mid_req_before", bus_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    m_rdata = '0; m_err = 1'b0;
    chk1("mid_req", bus_req, 1'b0);
    chk1("mid_done", done, 1'b0);
    chk32("mid_be", {28'd0, bus_be}, 32'h0);
    chk32("mid_addr", bus_addr, 32'h0);
    chk32("mid_wdata", bus_wdata, 32'h0);
    chk32("mid_rdata", rdata, 32'h0);
    chk1("mid_err", err, 1'b0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    idle(0);

    access(1, 0, 1, 32'h600, 32'h0, 32'h600DCAFE, 0);
    chk32("post_rst_rdata", rdata, 32'h600DCAFE);
    idle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
